ovl_fire_collector: RTL and testbench
=====================================

# ovl_fire_collector

Collects the single-bit fire outputs of up to NUM_CHK wrapped OVL checkers in the fabric and records each violation in a sticky flag and a saturating counter. Pending violations are reported to the host core one at a time, lowest checker index first, over a four-phase req/ack interrupt handshake. The block sits directly downstream of the wrapped checkers: each checker's `out` drives one bit of `fire`.

## Interface
Parameters:
- NUM_CHK, 8, number of checker inputs (1..32)
- ID_W, 3, checker index width; 2^ID_W >= NUM_CHK
- CNT_W, 8, per-checker violation counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  collection enable; 0 blocks capture of new fires
- fire  in  NUM_CHK  checker fire bits, bit i from checker i
- mask  in  NUM_CHK  1 = ignore fire[i]
- clr  in  1  synchronous clear of all collected state
- irq_req  out  1  interrupt request to host
- irq_id  out  ID_W  index of checker being reported
- irq_ack  in  1  host acknowledge
- pending  out  NUM_CHK  sticky per-checker violation flags
- overflow  out  1  sticky: a fire hit an already-pending checker
- count_sel  in  ID_W  counter read select
- count_out  out  CNT_W  counter of checker count_sel (combinational read)

## Operation
- Qualified fire: q[i] = fire[i] & ~mask[i] & enable.
- pending[i]: set on q[i]; cleared only when the host acknowledges checker i or on clr.
- cnt[i]: +1 on every cycle with q[i]; saturates at 2^CNT_W-1, never wraps.
- overflow: set when q[i] & pending[i] and pending[i] is not being cleared that cycle.
- count_out = cnt[count_sel]; count_sel >= NUM_CHK returns 0.
- mask/enable gate only new captures; already-pending flags and the handshake proceed unaffected.
- FSM (registered outputs):
  - IDLE: irq_req=0. If pending != 0: latch irq_id = lowest set index, go REQ.
  - REQ: irq_req=1, irq_id held stable. On irq_ack=1: clear pending[irq_id], go DROP.
  - DROP: irq_req=0. When irq_ack=0, go IDLE.
- irq_ack in IDLE is ignored; irq_ack held high after DROP keeps FSM in DROP.
- q[irq_id] in the same cycle as the ack clearing it: clear wins over set is false — pending[irq_id] stays 1, counter increments, overflow not set; the checker is reported again.
- clr: has priority over everything; clears pending, all cnt, overflow, irq_req, irq_id; FSM to IDLE on next edge. Fires in the clr cycle are discarded.

## Timing
- Reset (rst_n=0, async): irq_req=0, irq_id=0, pending=0, overflow=0, all cnt=0, FSM=IDLE; count_out reads 0.
- fire at edge t -> pending/cnt updated at t+1 -> irq_req=1 at t+2 (from IDLE).
- irq_ack sampled at t -> pending bit cleared and irq_req=0 at t+1.
- Minimum handshake: req high 1 cycle if ack returns immediately; next request no earlier than 1 cycle after ack is seen low.
- Reset asserted mid-handshake: irq_req drops asynchronously; host must tolerate abandoned request.
- count_out has zero-cycle latency from count_sel and reflects the registered counter.

## Test plan
- Reset then idle: rst_n low 3 cycles, fire=0 -> all outputs 0, FSM IDLE, no irq_req for 20 cycles.
- Single violation: fire=8'h04 one cycle -> pending=8'h04 next cycle, irq_req=1, irq_id=2 two cycles after; ack 1 cycle -> pending=0, req low; count_sel=2 -> count_out=1.
- Priority: fire=8'h90 one cycle -> irq_id=4 first; after full ack cycle irq_id=7; pending 8'h90 -> 8'h80 -> 8'h00.
- Mask/enable: mask=8'h01 with fire=8'h01, and enable=0 with fire=8'h02 -> pending stays 0, counters 0, no irq_req.
- Overflow and saturation (CNT_W=8): fire[3] held 300 cycles, host never acks -> cnt[3]=255, overflow=1, pending[3]=1; clr one cycle -> all 0, irq_req=0.
- Ack/fire collision: fire[5] pulses in the cycle irq_ack=1 for id 5 -> pending[5] remains 1, cnt[5]=2, overflow=0, second request with irq_id=5 after ack drops.

Source files
------------

// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: captures OVL checker fires into sticky flags and saturating counters,
// and reports pending checkers to the host lowest-index first over a req/ack handshake.
module ovl_fire_collector #(
  parameter int NUM_CHK = 8,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_CHK-1:0] fire,
  input  logic [NUM_CHK-1:0] mask,
  input  logic               clr,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic [NUM_CHK-1:0] pending,
  output logic               overflow,
  input  logic [ID_W-1:0]    count_sel,
  output logic [CNT_W-1:0]   count_out
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;
  state_e             state_q;
  logic [NUM_CHK-1:0] pending_q, pending_d, q, ack_vec;
  logic               overflow_q, overflow_d, irq_req_q;
  logic [ID_W-1:0]    irq_id_q, low_id;
  logic [CNT_W-1:0]   cnt_q [NUM_CHK];
  always_comb begin
    q          = fire & ~mask & {NUM_CHK{enable}};
    ack_vec    = (state_q == REQ && irq_ack) ? NUM_CHK'(1) << irq_id_q : '0;
    // a fire on the checker being acknowledged re-arms it rather than overflowing
    pending_d  = (pending_q & ~ack_vec) | q;
    overflow_d = overflow_q | (|(q & pending_q & ~ack_vec));
    low_id     = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--)
      if (pending_q[i]) low_id = ID_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_CHK; i++)
        if (q[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      case (state_q)
        IDLE: if (|pending_q) begin
          irq_id_q  <= low_id;
          irq_req_q <= 1'b1;
          state_q   <= REQ;
        end
        REQ: if (irq_ack) begin
          irq_req_q <= 1'b0;
          state_q   <= DROP;
        end
        DROP: if (!irq_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign irq_req   = irq_req_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign count_out = (32'(count_sel) < NUM_CHK) ? cnt_q[count_sel] : '0;
endmodule

// File: tb/tb_ovl_fire_collector.sv
// tb_ovl_fire_collector: directed and randomized checks against a behavioural model of the collector.
module tb_ovl_fire_collector;
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr = 1'b0, irq_ack = 1'b0;
  logic [7:0] fire = '0, mask = '0;
  logic [2:0] count_sel = '0;
  logic       irq_req, overflow;
  logic [2:0] irq_id;
  logic [7:0] pending, count_out;
  int checks = 0, errors = 0;
  bit m_pend [8];
  int m_cnt  [8];
  bit m_ovf, m_req;
  int m_id, m_phase;

  ovl_fire_collector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fire(fire), .mask(mask), .clr(clr),
    .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .pending(pending),
    .overflow(overflow), .count_sel(count_sel), .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
    m_ovf = 0; m_req = 0; m_id = 0; m_phase = 0;
  endtask

  // phase 0: nothing outstanding, 1: request raised, 2: waiting for host to drop ack
  task automatic model_edge();
    bit any, found;
    int clear_i;
    if (clr) begin model_reset(); return; end
    any = 0;
    for (int i = 0; i < 8; i++) any |= m_pend[i];
    clear_i = (m_phase == 1 && irq_ack) ? m_id : -1;
    if (m_phase == 0 && any) begin
      found = 0;
      for (int i = 0; i < 8; i++) if (m_pend[i] && !found) begin m_id = i; found = 1; end
      m_phase = 1;
    end else if (m_phase == 1 && irq_ack) m_phase = 2;
    else if (m_phase == 2 && !irq_ack) m_phase = 0;
    m_req = (m_phase == 1);
    for (int i = 0; i < 8; i++) begin
      bit hit = fire[i] && !mask[i] && enable;
      if (hit && m_pend[i] && clear_i != i) m_ovf = 1;
      m_pend[i] = hit || (m_pend[i] && clear_i != i);
      if (hit && m_cnt[i] < 255) m_cnt[i]++;
    end
  endtask

  task automatic compare_all();
    chk("irq_req", irq_req, m_req);
    if (m_req) chk("irq_id", irq_id, m_id);
    chk("pending", pending, m_pend_vec());
    chk("overflow", overflow, m_ovf);
    chk("count_out", count_out, m_cnt[count_sel]);
  endtask

  task automatic step(input logic en, input logic [7:0] f, input logic [7:0] m,
                      input logic c, input logic a, input logic [2:0] s);
    enable = en; fire = f; mask = m; clr = c; irq_ack = a; count_sel = s;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    chk("rst_count", count_out, 0);
    rst_n = 1'b1;
    repeat (20) step(1, 0, 0, 0, 0, 3'($urandom_range(0, 7)));
    // single violation on checker 2
    step(1, 8'h04, 0, 0, 0, 2);
    chk("single_pend", pending, 8'h04);
    step(1, 0, 0, 0, 0, 2);
    chk("single_req", irq_req, 1);
    chk("single_id", irq_id, 2);
    step(1, 0, 0, 0, 1, 2);
    chk("single_clr", pending, 0);
    chk("single_drop", irq_req, 0);
    step(1, 0, 0, 0, 0, 2);
    chk("single_cnt", count_out, 1);
    // priority: 4 before 7
    step(1, 8'h90, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("prio_first", irq_id, 4);
    step(1, 0, 0, 0, 1, 0);
    chk("prio_mid", pending, 8'h80);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("prio_second", irq_id, 7);
    step(1, 0, 0, 0, 1, 0);
    chk("prio_done", pending, 0);
    step(1, 0, 0, 0, 0, 0);
    // mask and enable gating
    step(1, 8'h01, 8'h01, 0, 0, 0);
    step(0, 8'h02, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("gate_pend", pending, 0);
    chk("gate_cnt", count_out, 0);
    chk("gate_req", irq_req, 0);
    // saturation and overflow, then clear
    step(1, 0, 0, 1, 0, 0);
    repeat (300) step(1, 8'h08, 0, 0, 0, 3);
    chk("sat_cnt", count_out, 255);
    chk("sat_ovf", overflow, 1);
    chk("sat_pend", pending[3], 1);
    step(1, 8'h08, 0, 1, 0, 3);
    chk("clr_cnt", count_out, 0);
    chk("clr_req", irq_req, 0);
    chk("clr_pend", pending, 0);
    chk("clr_ovf", overflow, 0);
    // ack/fire collision on checker 5
    step(1, 8'h20, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0, 5);
    chk("col_id", irq_id, 5);
    step(1, 8'h20, 0, 0, 1, 5);
    chk("col_pend", pending[5], 1);
    chk("col_cnt", count_out, 2);
    chk("col_ovf", overflow, 0);
    step(1, 0, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0, 5);
    chk("col_rereq", irq_req, 1);
    chk("col_reid", irq_id, 5);
    // asynchronous reset mid-handshake
    #2 rst_n = 1'b0;
    #1 chk("async_req", irq_req, 0);
    chk("async_pend", pending, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    // randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) != 0, 8'($urandom & $urandom & $urandom), 8'($urandom & $urandom),
           $urandom_range(0, 99) == 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
